sap_core: RTL and testbench

Parametrised multi-cycle accumulator CPU core: the next generation of the 8-bit bus machine (PC, MAR, IR, accumulator, B register, add/sub ALU, output register, control sequencer). It generalises data and address width, moves program/data memory outside the core behind a simple synchronous-write/combinational-read port, and adds store, immediate load, unconditional and conditional jumps, registered flags and an explicit halt state. It sits at the top of the processor datapath; the memory and output devices hang off its ports.

---
 rtl/sap_pkg.sv | 40 ++++
 rtl/sap_alu.sv | 25 ++
 rtl/sap_core.sv | 164 ++++++++++++++++
 tb/tb_sap_core.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/sap_pkg.sv
// Shared definitions for the sap_core accumulator CPU: opcodes, sequencer
// states and instruction-field helpers.
package sap_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    ST_F1   = 3'd0,
    ST_F2   = 3'd1,
    ST_DEC  = 3'd2,
    ST_E1   = 3'd3,
    ST_E2   = 3'd4,
    ST_HALT = 3'd5
  } state_e;

  // Helpers take the instruction zero-extended to 32 bits so one definition
  // serves every DATA_W/ADDR_W; callers cast the result to the field width.
  function automatic logic [3:0] ir_opcode(input logic [31:0] ir, input int data_w);
    return 4'((ir >> (data_w - 4)) & 32'hF);
  endfunction

  function automatic logic [31:0] ir_addr(input logic [31:0] ir, input int addr_w);
    return ir & ((32'd1 << addr_w) - 32'd1);
  endfunction

  function automatic logic [31:0] ir_imm(input logic [31:0] ir, input int data_w);
    return ir & ((32'd1 << (data_w - 4)) - 32'd1);
  endfunction

endpackage

// File: rtl/sap_alu.sv
// Combinational add/subtract unit for sap_core; subtraction is acc + ~b + 1
// so carry reads as "no borrow".
module sap_alu
  import sap_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic              i_sub,
  output logic [DATA_W-1:0] o_result,
  output logic              o_carry,
  output logic              o_zero
);

  logic [DATA_W-1:0] w_b_eff;
  logic [DATA_W:0]   w_sum;

  assign w_b_eff  = i_sub ? ~i_b : i_b;
  assign w_sum    = {1'b0, i_a} + {1'b0, w_b_eff} + {{DATA_W{1'b0}}, i_sub};
  assign o_result = w_sum[DATA_W-1:0];
  assign o_carry  = w_sum[DATA_W];
  assign o_zero   = (w_sum[DATA_W-1:0] == '0);

endmodule

// File: rtl/sap_core.sv
// Multi-cycle accumulator CPU core with external memory port.
// Optional SAP_COND_JUMP_EN enables JC/JZ; otherwise opcodes 7/8 run as NOP.
//
// state | meaning
// F1    | mar <- pc
// F2    | ir <- memory, pc <- pc + 1
// DEC   | finish single-cycle ops, or mar <- operand address
// E1    | memory access (LDA load, STA write, ADD/SUB b <- memory)
// E2    | acc <- ALU, flags updated
// HALT  | frozen until reset
module sap_core
  import sap_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              low_clr,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              carry_flag,
  output logic              zero_flag,
  output logic              halted
);

`ifdef SAP_COND_JUMP_EN
  localparam bit COND_JUMP_EN = 1'b1;
`else
  localparam bit COND_JUMP_EN = 1'b0;
`endif

  state_e            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_mar;
  logic [DATA_W-1:0] r_ir;
  logic [DATA_W-1:0] r_acc;
  logic [DATA_W-1:0] r_b;
  logic [DATA_W-1:0] r_out;
  logic              r_out_valid;
  logic              r_mem_we;
  logic              r_carry;
  logic              r_zero;
  logic              r_halted;

  logic [3:0]        w_opcode;
  logic [ADDR_W-1:0] w_op_addr;
  logic [DATA_W-1:0] w_imm;
  logic [DATA_W-1:0] w_alu_result;
  logic              w_alu_carry;
  logic              w_alu_zero;
  logic              w_alu_sub;

  assign w_opcode  = ir_opcode(32'(r_ir), DATA_W);
  assign w_op_addr = ADDR_W'(ir_addr(32'(r_ir), ADDR_W));
  assign w_imm     = DATA_W'(ir_imm(32'(r_ir), DATA_W));
  assign w_alu_sub = (w_opcode == OP_SUB);

  sap_alu #(
    .DATA_W(DATA_W)
  ) u_alu (
    .i_a     (r_acc),
    .i_b     (r_b),
    .i_sub   (w_alu_sub),
    .o_result(w_alu_result),
    .o_carry (w_alu_carry),
    .o_zero  (w_alu_zero)
  );

  always_ff @(posedge clk or negedge low_clr) begin
    if (!low_clr) begin
      r_state     <= ST_F1;
      r_pc        <= '0;
      r_mar       <= '0;
      r_ir        <= '0;
      r_acc       <= '0;
      r_b         <= '0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
      r_mem_we    <= 1'b0;
      r_carry     <= 1'b0;
      r_zero      <= 1'b0;
      r_halted    <= 1'b0;
    end else begin
      // Strobes are single-cycle: asserted by one state, dropped by the next edge.
      r_out_valid <= 1'b0;
      r_mem_we    <= 1'b0;
      case (r_state)
        ST_F1: begin
          r_mar   <= r_pc;
          r_state <= ST_F2;
        end
        ST_F2: begin
          r_ir    <= mem_rdata;
          r_pc    <= r_pc + ADDR_W'(1);
          r_state <= ST_DEC;
        end
        ST_DEC: begin
          r_state <= ST_F1;
          case (w_opcode)
            OP_LDA, OP_ADD, OP_SUB: begin
              r_mar   <= w_op_addr;
              r_state <= ST_E1;
            end
            OP_STA: begin
              r_mar    <= w_op_addr;
              r_mem_we <= 1'b1;
              r_state  <= ST_E1;
            end
            OP_LDI: r_acc <= w_imm;
            OP_JMP: r_pc <= w_op_addr;
            OP_JC: begin
              if (COND_JUMP_EN && r_carry) r_pc <= w_op_addr;
            end
            OP_JZ: begin
              if (COND_JUMP_EN && r_zero) r_pc <= w_op_addr;
            end
            OP_OUT: begin
              r_out       <= r_acc;
              r_out_valid <= 1'b1;
            end
            OP_HLT: begin
              r_state  <= ST_HALT;
              r_halted <= 1'b1;
            end
            default: ;
          endcase
        end
        ST_E1: begin
          r_state <= ST_F1;
          case (w_opcode)
            OP_LDA: r_acc <= mem_rdata;
            OP_ADD, OP_SUB: begin
              r_b     <= mem_rdata;
              r_state <= ST_E2;
            end
            default: ;
          endcase
        end
        ST_E2: begin
          r_acc   <= w_alu_result;
          r_carry <= w_alu_carry;
          r_zero  <= w_alu_zero;
          r_state <= ST_F1;
        end
        ST_HALT: ;
        default: r_state <= ST_F1;
      endcase
    end
  end

  assign mem_addr   = r_mar;
  assign mem_wdata  = r_acc;
  assign mem_we     = r_mem_we;
  assign out_data   = r_out;
  assign out_valid  = r_out_valid;
  assign carry_flag = r_carry;
  assign zero_flag  = r_zero;
  assign halted     = r_halted;

endmodule

// File: tb/tb_sap_core.sv
// Directed self-checking bench for sap_core (DATA_W=8, ADDR_W=4) with a
// 16-word memory model on the core's memory port.
module tb_sap_core;

  logic       clk;
  logic       low_clr;
  logic [3:0] mem_addr;
  logic [7:0] mem_rdata;
  logic [7:0] mem_wdata;
  logic       mem_we;
  logic [7:0] out_data;
  logic       out_valid;
  logic       carry_flag;
  logic       zero_flag;
  logic       halted;

  logic [7:0] mem [0:15];
  int n_checks;
  int n_fail;

  sap_core #(.DATA_W(8), .ADDR_W(4)) dut (
    .clk       (clk),
    .low_clr   (low_clr),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .out_data  (out_data),
    .out_valid (out_valid),
    .carry_flag(carry_flag),
    .zero_flag (zero_flag),
    .halted    (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

  task automatic clear_mem();
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
  endtask

  // Hold reset while a program is loaded, release on a falling edge.
  task automatic restart();
    low_clr = 1'b0;
    @(negedge clk);
    low_clr = 1'b1;
  endtask

  task automatic test_reset();
    low_clr = 1'b0;
    clear_mem();
    repeat (2) @(negedge clk);
    n_checks++; if (mem_addr !== 4'h0) begin n_fail++; $display("FAIL reset_mem_addr: got %h expected 0", mem_addr); end
    n_checks++; if (mem_wdata !== 8'h00) begin n_fail++; $display("FAIL reset_acc: got %h expected 00", mem_wdata); end
    n_checks++; if ({mem_we, out_valid, carry_flag, zero_flag, halted} !== 5'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b expected 00000", {mem_we, out_valid, carry_flag, zero_flag, halted}); end
    n_checks++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL reset_out: got %h expected 00", out_data); end
  endtask

  task automatic test_reset_mid_add();
    clear_mem();
    mem[0] = 8'h1E; mem[1] = 8'h2F; mem[2] = 8'h53; mem[3] = 8'hE0; mem[4] = 8'h2A;
    mem[4'hA] = 8'h05; mem[4'hE] = 8'hFF; mem[4'hF] = 8'h01;
    restart();
    // LDA 4 + ADD 5 + LDI 3 + OUT 3 = 15, then ADD F1/F2/DEC brings it to E1.
    repeat (19) @(negedge clk);
    n_checks++; if (mem_addr !== 4'hA) begin n_fail++; $display("FAIL midadd_addr: got %h expected a", mem_addr); end
    n_checks++; if ({carry_flag, zero_flag} !== 2'b11) begin n_fail++; $display("FAIL midadd_flags: got %b expected 11", {carry_flag, zero_flag}); end
    n_checks++; if (out_data !== 8'h03) begin n_fail++; $display("FAIL midadd_out: got %h expected 03", out_data); end
    low_clr = 1'b0;
    #1;
    n_checks++; if (mem_addr !== 4'h0) begin n_fail++; $display("FAIL midadd_rst_addr: got %h expected 0", mem_addr); end
    n_checks++; if ({mem_wdata, out_data} !== 16'h0000) begin n_fail++; $display("FAIL midadd_rst_regs: got %h expected 0000", {mem_wdata, out_data}); end
    n_checks++; if ({carry_flag, zero_flag, halted} !== 3'b000) begin n_fail++; $display("FAIL midadd_rst_flags: got %b expected 000", {carry_flag, zero_flag, halted}); end
    @(negedge clk);
    low_clr = 1'b1;
    @(negedge clk);
    n_checks++; if (mem_addr !== 4'h0) begin n_fail++; $display("FAIL refetch_addr: got %h expected 0", mem_addr); end
    repeat (2) @(negedge clk);
    n_checks++; if (mem_addr !== 4'hE) begin n_fail++; $display("FAIL refetch_operand: got %h expected e", mem_addr); end
  endtask

  task automatic test_add_out_halt();
    int pulses, pulse_cyc, halt_cyc;
    logic [7:0] seen;
    clear_mem();
    mem[0] = 8'h19; mem[1] = 8'h2A; mem[2] = 8'hE0; mem[3] = 8'hF0;
    mem[9] = 8'h1C; mem[4'hA] = 8'h0E;
    restart();
    pulses = 0; pulse_cyc = -1; halt_cyc = -1; seen = 8'h00;
    for (int c = 1; c <= 22; c++) begin
      @(negedge clk);
      if (out_valid) begin pulses++; pulse_cyc = c; seen = out_data; end
      if (halted && halt_cyc < 0) halt_cyc = c;
    end
    n_checks++; if (pulses !== 1) begin n_fail++; $display("FAIL add_pulses: got %0d expected 1", pulses); end
    n_checks++; if (pulse_cyc !== 12) begin n_fail++; $display("FAIL add_pulse_cycle: got %0d expected 12", pulse_cyc); end
    n_checks++; if (seen !== 8'h2A) begin n_fail++; $display("FAIL add_out: got %h expected 2a", seen); end
    n_checks++; if (halt_cyc !== 15) begin n_fail++; $display("FAIL add_halt_cycle: got %0d expected 15", halt_cyc); end
    n_checks++; if ({carry_flag, zero_flag} !== 2'b00) begin n_fail++; $display("FAIL add_flags: got %b expected 00", {carry_flag, zero_flag}); end
    n_checks++; if ({mem_we, out_valid, mem_addr} !== 6'b00_0011) begin
      n_fail++; $display("FAIL halt_frozen: got %b expected 000011", {mem_we, out_valid, mem_addr}); end
  endtask

  task automatic test_sub();
    clear_mem();
    mem[0] = 8'h55; mem[1] = 8'h3F; mem[2] = 8'hE0; mem[3] = 8'h3E; mem[4] = 8'hF0;
    mem[4'hF] = 8'h05; mem[4'hE] = 8'h01;
    restart();
    repeat (8) @(negedge clk);
    n_checks++; if (mem_wdata !== 8'h00) begin n_fail++; $display("FAIL sub_eq_acc: got %h expected 00", mem_wdata); end
    n_checks++; if ({carry_flag, zero_flag} !== 2'b11) begin n_fail++; $display("FAIL sub_eq_flags: got %b expected 11", {carry_flag, zero_flag}); end
    repeat (8) @(negedge clk);
    n_checks++; if (mem_wdata !== 8'hFF) begin n_fail++; $display("FAIL sub_borrow_acc: got %h expected ff", mem_wdata); end
    n_checks++; if ({carry_flag, zero_flag} !== 2'b00) begin n_fail++; $display("FAIL sub_borrow_flags: got %b expected 00", {carry_flag, zero_flag}); end
  endtask

  task automatic test_store();
    int pulses, pulse_cyc;
    logic [3:0] we_addr;
    logic [7:0] we_data;
    clear_mem();
    mem[0] = 8'h57; mem[1] = 8'h4D; mem[2] = 8'h50; mem[3] = 8'h1D; mem[4] = 8'hE0; mem[5] = 8'hF0;
    restart();
    pulses = 0; pulse_cyc = -1; we_addr = 4'h0; we_data = 8'h00;
    for (int c = 1; c <= 22; c++) begin
      @(negedge clk);
      if (mem_we) begin pulses++; pulse_cyc = c; we_addr = mem_addr; we_data = mem_wdata; end
    end
    n_checks++; if (pulses !== 1) begin n_fail++; $display("FAIL sta_pulses: got %0d expected 1", pulses); end
    n_checks++; if (pulse_cyc !== 6) begin n_fail++; $display("FAIL sta_cycle: got %0d expected 6", pulse_cyc); end
    n_checks++; if ({we_addr, we_data} !== 12'hD07) begin n_fail++; $display("FAIL sta_bus: got %h expected d07", {we_addr, we_data}); end
    n_checks++; if (mem[4'hD] !== 8'h07) begin n_fail++; $display("FAIL sta_mem: got %h expected 07", mem[4'hD]); end
    n_checks++; if (out_data !== 8'h07) begin n_fail++; $display("FAIL lda_readback: got %h expected 07", out_data); end
    n_checks++; if (halted !== 1'b1) begin n_fail++; $display("FAIL sta_halted: got %b expected 1", halted); end
  endtask

  task automatic test_pc_wrap();
    logic [3:0] exp_addr;
    clear_mem();
    restart();
    @(negedge clk);
    // Each NOP takes 3 cycles; sample the fetch address at every F2.
    for (int k = 0; k < 18; k++) begin
      exp_addr = 4'(k);
      n_checks++; if (mem_addr !== exp_addr) begin n_fail++; $display("FAIL wrap_fetch_%0d: got %h expected %h", k, mem_addr, exp_addr); end
      repeat (3) @(negedge clk);
    end
    n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL wrap_halted: got %b expected 0", halted); end
  endtask

  task automatic test_cond_jump();
    logic [3:0] exp_fetch;
    int exp_halt;
`ifdef SAP_COND_JUMP_EN
    exp_fetch = 4'h3; exp_halt = 18;
`else
    exp_fetch = 4'hB; exp_halt = 21;
`endif
    clear_mem();
    mem[0] = 8'h68; mem[8] = 8'h1E; mem[9] = 8'h2F; mem[4'hA] = 8'h73;
    mem[3] = 8'hF0; mem[4'hB] = 8'hE0; mem[4'hC] = 8'hF0;
    mem[4'hE] = 8'hFF; mem[4'hF] = 8'h01;
    restart();
    repeat (4) @(negedge clk);
    n_checks++; if (mem_addr !== 4'h8) begin n_fail++; $display("FAIL jmp_fetch: got %h expected 8", mem_addr); end
    repeat (8) @(negedge clk);
    n_checks++; if ({mem_wdata, carry_flag, zero_flag} !== 10'b0000_0000_11) begin
      n_fail++; $display("FAIL ovf_add: got %b expected 0000000011", {mem_wdata, carry_flag, zero_flag}); end
    repeat (4) @(negedge clk);
    n_checks++; if (mem_addr !== exp_fetch) begin n_fail++; $display("FAIL jc_fetch: got %h expected %h", mem_addr, exp_fetch); end
    repeat (exp_halt - 17) @(negedge clk);
    n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL jc_early_halt: got %b expected 0", halted); end
    @(negedge clk);
    n_checks++; if (halted !== 1'b1) begin n_fail++; $display("FAIL jc_halt: got %b expected 1", halted); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    low_clr  = 1'b0;
    test_reset();
    test_reset_mid_add();
    test_add_out_halt();
    test_sub();
    test_store();
    test_pc_wrap();
    test_cond_jump();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
